pipe_fetch: RTL



---
 rtl/pipe_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage plus IF/ID register, with a req/ack instruction port
// and a single branch delay slot. Optional alignment trap: PIPE_FETCH_ALIGN_TRAP_EN.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        ifault
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] inst_buf;
  logic        redir_pend;
  logic [31:0] redir_tgt;

  logic [31:0] pc_plus4;
  logic [31:0] raw_tgt;
  logic [31:0] tgt;
  logic [31:0] next_pc;
  logic        capture;
  logic        fetch_done;

  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;

  // A redirect is only honoured while ID is not stalled.
  assign capture    = !wpcir && (pcsource != 2'b00);
  assign fetch_done = !wpcir && (((state == ST_REQ) && imem_ack) || (state == ST_HOLD));

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here via the default arm), otherwise synthesis infers a latch.
  always_comb begin
    case (pcsource)
      2'b01:   raw_tgt = bpc;
      2'b10:   raw_tgt = da;
      2'b11:   raw_tgt = jpc;
      default: raw_tgt = pc_plus4;
    endcase
  end

`ifdef PIPE_FETCH_ALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (raw_tgt[1:0] != 2'b00);
  assign tgt        = {raw_tgt[31:2], 2'b00};

  always_ff @(posedge clock) begin
    if (!resetn)
      ifault <= 1'b0;
    else if (capture && misaligned)
      ifault <= 1'b1;
  end
`else
  assign tgt    = raw_tgt;
  assign ifault = 1'b0;
`endif

  // A same-edge redirect beats an older pending one; otherwise fall through.
  assign next_pc = capture    ? tgt       :
                   redir_pend ? redir_tgt :
                                pc_plus4;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      dpc4       <= 32'd0;
      inst       <= 32'd0;
      inst_buf   <= 32'd0;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_REQ;
        ST_REQ: begin
          if (imem_ack) begin
            if (!wpcir) begin
              dpc4 <= pc_plus4;
              inst <= imem_rdata;
            end else begin
              // ID is stalled: park the word so the fetch is not lost.
              inst_buf <= imem_rdata;
              state    <= ST_HOLD;
            end
          end else if (!wpcir) begin
            inst <= 32'd0;
          end
        end
        ST_HOLD: begin
          if (!wpcir) begin
            dpc4  <= pc_plus4;
            inst  <= inst_buf;
            state <= ST_REQ;
          end
        end
        default: state <= ST_BOOT;
      endcase

      if (fetch_done) begin
        pc         <= next_pc;
        redir_pend <= 1'b0;
      end else if (capture) begin
        redir_tgt  <= tgt;
        redir_pend <= 1'b1;
      end
    end
  end

endmodule
